rheed_result_packer: RTL and testbench

RHEED_RESULT_PACKER -- requirements
Module: rheed_result_packer

---
 rtl/rheed_pkg.sv | 54 +++++
 rtl/rheed_argmax.sv | 34 +++
 rtl/rheed_result_packer.sv | 154 +++++++++++++++
 tb/tb_rheed_result_packer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rheed_pkg.sv
// Shared definitions for the RHEED result packer: FSM states, output-word layout
// and small helpers used when building the host word.
package rheed_pkg;

  localparam int OUT_WORD_W  = 256;
  localparam int W_SCORES    = 40;
  localparam int OFF_SCORES  = 0;
  localparam int OFF_ARGMAX  = 40;
  localparam int OFF_MAX     = 48;
  localparam int OFF_SEQ     = 56;
  localparam int OFF_X0      = 72;
  localparam int OFF_Y0      = 80;
  localparam int OFF_TIMEOUT = 88;
  localparam int OFF_OVERRUN = 96;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RES = 2'd1,
    ARGMAX   = 2'd2,
    SEND     = 2'd3
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  function automatic logic [OUT_WORD_W-1:0] pack_word(
    input logic [W_SCORES-1:0] scores,
    input logic [7:0]          idx,
    input logic [7:0]          max_v,
    input logic [15:0]         seq,
    input logic [7:0]          x0,
    input logic [7:0]          y0,
    input logic                to,
    input logic [7:0]          ovr
  );
    logic [OUT_WORD_W-1:0] w;
    w = '0;
    w[OFF_SCORES +: W_SCORES] = scores;
    w[OFF_ARGMAX +: 8]        = idx;
    w[OFF_MAX +: 8]           = max_v;
    w[OFF_SEQ +: 16]          = seq;
    w[OFF_X0 +: 8]            = x0;
    w[OFF_Y0 +: 8]            = y0;
    w[OFF_TIMEOUT]            = to;
    w[OFF_OVERRUN +: 8]       = ovr;
    return w;
  endfunction

endpackage

// File: rtl/rheed_argmax.sv
// Combinational signed argmax over NUM_CLASSES packed scores; ties resolve to
// the lowest class index.
module rheed_argmax
  import rheed_pkg::*;
#(
  parameter int NUM_CLASSES     = 5,
  parameter int PIXEL_BIT_WIDTH = 8,
  parameter int IDX_W           = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic [PIXEL_BIT_WIDTH*NUM_CLASSES-1:0] scores_i,
  output logic [IDX_W-1:0]                       index_o,
  output logic signed [PIXEL_BIT_WIDTH-1:0]      max_o
);

  logic signed [PIXEL_BIT_WIDTH-1:0] cur_s;

  // Linear scan; strict greater-than keeps the earliest of equal maxima
  always_comb begin
    index_o = '0;
    max_o   = $signed(scores_i[PIXEL_BIT_WIDTH-1:0]);
    cur_s   = '0;
    for (int i = 1; i < NUM_CLASSES; i++) begin
      cur_s = $signed(scores_i[i*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH]);
      if (cur_s > max_o) begin
        max_o   = cur_s;
        index_o = i[IDX_W-1:0];
      end else begin
        max_o   = max_o;
        index_o = index_o;
      end
    end
  end

endmodule

// File: rtl/rheed_result_packer.sv
// Waits for one CNN class-score result per frame start, picks the argmax and
// emits a single 256-bit host word, with timeout and overrun reporting.
module rheed_result_packer
  import rheed_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 8,
  parameter int NUM_CLASSES     = 5,
  parameter int TIMEOUT_CYCLES  = 1048576
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   ap_start,
  input  logic [7:0]                             crop_x0,
  input  logic [6:0]                             crop_y0,
  input  logic                                   s_axis_tvalid,
  output logic                                   s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH*NUM_CLASSES-1:0] s_axis_tdata,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic [OUT_WORD_W-1:0]                  m_axis_tdata,
  output logic                                   m_axis_tlast,
  output logic                                   busy
);

  localparam int SCORE_W = PIXEL_BIT_WIDTH * NUM_CLASSES;
  localparam int IDX_W   = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                       state_q;
  logic [7:0]                   crop_x_q;
  logic [6:0]                   crop_y_q;
  logic [CNT_W-1:0]             tmo_cnt_q;
  logic [SCORE_W-1:0]           scores_q;
  logic [15:0]                  frame_seq_q;
  logic [7:0]                   overrun_q;
  logic [7:0]                   overrun_d;
  logic [7:0]                   ovr_base_s;
  logic [OUT_WORD_W-1:0]        word_q;
  logic                         s_tready_q;
  logic                         m_tvalid_q;
  logic                         busy_q;
  logic                         s_hs_s;
  logic                         m_hs_s;
  logic [IDX_W-1:0]             argmax_idx_s;
  logic signed [PIXEL_BIT_WIDTH-1:0] argmax_max_s;

  rheed_argmax #(
    .NUM_CLASSES     (NUM_CLASSES),
    .PIXEL_BIT_WIDTH (PIXEL_BIT_WIDTH),
    .IDX_W           (IDX_W)
  ) u_argmax (
    .scores_i (scores_q),
    .index_o  (argmax_idx_s),
    .max_o    (argmax_max_s)
  );

  assign s_hs_s = (state_q == WAIT_RES) && s_axis_tvalid;
  assign m_hs_s = m_tvalid_q && m_axis_tready;

  // Only the overrun count already reported in the outgoing word is retired,
  // so starts arriving after the word was built are not lost
  always_comb begin
    if (m_hs_s) begin
      ovr_base_s = overrun_q - word_q[OFF_OVERRUN +: 8];
    end else begin
      ovr_base_s = overrun_q;
    end
    if (ap_start && (state_q != IDLE)) begin
      overrun_d = sat_inc8(ovr_base_s);
    end else begin
      overrun_d = ovr_base_s;
    end
  end

  // Frame FSM with registered handshake, busy and result-word outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      crop_x_q    <= 8'd0;
      crop_y_q    <= 7'd0;
      tmo_cnt_q   <= '0;
      scores_q    <= '0;
      frame_seq_q <= 16'd0;
      overrun_q   <= 8'd0;
      word_q      <= '0;
      s_tready_q  <= 1'b0;
      m_tvalid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      case (state_q)
        IDLE: begin
          if (ap_start) begin
            crop_x_q   <= crop_x0;
            crop_y_q   <= crop_y0;
            tmo_cnt_q  <= '0;
            s_tready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= WAIT_RES;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT_RES: begin
          if (s_hs_s) begin
            scores_q   <= s_axis_tdata;
            s_tready_q <= 1'b0;
            state_q    <= ARGMAX;
          end else if (tmo_cnt_q == CNT_LAST) begin
            word_q     <= pack_word('0, 8'd0, 8'd0, frame_seq_q, crop_x_q,
                                    {1'b0, crop_y_q}, 1'b1, overrun_d);
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b1;
            state_q    <= SEND;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end
        end
        ARGMAX: begin
          word_q     <= pack_word(W_SCORES'(scores_q), 8'(argmax_idx_s),
                                  8'($unsigned(argmax_max_s)), frame_seq_q,
                                  crop_x_q, {1'b0, crop_y_q}, 1'b0, overrun_d);
          m_tvalid_q <= 1'b1;
          state_q    <= SEND;
        end
        SEND: begin
          if (m_axis_tready) begin
            word_q      <= '0;
            m_tvalid_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_seq_q <= frame_seq_q + 16'd1;
            state_q     <= IDLE;
          end else begin
            state_q <= SEND;
          end
        end
        default: begin
          s_tready_q <= 1'b0;
          m_tvalid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign s_axis_tready = s_tready_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tvalid_q;
  assign m_axis_tdata  = word_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_rheed_result_packer.sv
// Directed bench for rheed_result_packer: normal, negative, backpressure,
// overrun, timeout, handshake/timeout race and mid-frame reset.
module tb_rheed_result_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic         ap_start;
  logic [7:0]   crop_x0;
  logic [6:0]   crop_y0;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [39:0]  s_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [255:0] m_axis_tdata;
  logic         m_axis_tlast;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_w;

  always #5 clk = ~clk;

  rheed_result_packer #(
    .PIXEL_BIT_WIDTH (8),
    .NUM_CLASSES     (5),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ap_start      (ap_start),
    .crop_x0       (crop_x0),
    .crop_y0       (crop_y0),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy)
  );

  function automatic logic [255:0] ew(input logic [39:0] sc, input logic [7:0] idx,
                                      input logic [7:0] mx, input logic [15:0] seq,
                                      input logic [7:0] x0, input logic [6:0] y0,
                                      input logic to, input logic [7:0] ovr);
    logic [255:0] w;
    w = '0;
    w[39:0]   = sc;
    w[47:40]  = idx;
    w[55:48]  = mx;
    w[71:56]  = seq;
    w[79:72]  = x0;
    w[87:80]  = {1'b0, y0};
    w[88]     = to;
    w[103:96] = ovr;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] x, input logic [6:0] y);
    crop_x0  = x;
    crop_y0  = y;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
  endtask

  task automatic offer(input logic [39:0] d);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic accept();
    m_axis_tready = 1'b1;
    step();
    m_axis_tready = 1'b0;
    chk("accept_tvalid", m_axis_tvalid, 0);
  endtask

  initial begin
    reset = 1'b1; ap_start = 1'b0; crop_x0 = 8'd0; crop_y0 = 7'd0;
    s_axis_tvalid = 1'b0; s_axis_tdata = 40'd0; m_axis_tready = 1'b0;
    step(); step();
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast",  m_axis_tlast, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_tdata",  m_axis_tdata, 0);
    reset = 1'b0;
    step();

    // Normal frame, tie between classes 2 and 4
    start(8'd10, 7'd20);
    chk("f1_busy", busy, 1);
    chk("f1_tready", s_axis_tready, 1);
    offer(40'h5A0C5AFD05);
    chk("f1_tready_after", s_axis_tready, 0);
    chk("f1_lat1_tvalid", m_axis_tvalid, 0);
    step();
    chk("f1_lat2_tvalid", m_axis_tvalid, 1);
    chk("f1_tlast", m_axis_tlast, 1);
    chk("f1_word", m_axis_tdata, ew(40'h5A0C5AFD05, 8'd2, 8'h5A, 16'd0, 8'd10, 7'd20, 1'b0, 8'd0));
    accept();
    chk("f1_idle_busy", busy, 0);

    // All-negative scores, then 10 cycles of backpressure
    start(8'd3, 7'd4);
    offer(40'hFB80FEFF80);
    step();
    exp_w = ew(40'hFB80FEFF80, 8'd1, 8'hFF, 16'd1, 8'd3, 7'd4, 1'b0, 8'd0);
    chk("f2_word", m_axis_tdata, exp_w);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("f2_bp_tvalid", m_axis_tvalid, 1);
      chk("f2_bp_word", m_axis_tdata, exp_w);
    end
    accept();

    // Three starts while waiting -> overrun reported once
    start(8'd1, 7'd2);
    crop_x0 = 8'd99; crop_y0 = 7'd99; ap_start = 1'b1;
    step(); step(); step();
    ap_start = 1'b0;
    offer(40'h0504030201);
    step();
    chk("f3_word", m_axis_tdata, ew(40'h0504030201, 8'd4, 8'h05, 16'd2, 8'd1, 7'd2, 1'b0, 8'd3));
    accept();

    // Result offered in IDLE stays pending until the next start
    s_axis_tdata = 40'h0000000007; s_axis_tvalid = 1'b1;
    step(); step();
    chk("f4_idle_tready", s_axis_tready, 0);
    chk("f4_idle_busy", busy, 0);
    crop_x0 = 8'd6; crop_y0 = 7'd7; ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    chk("f4_wait_tready", s_axis_tready, 1);
    step();
    s_axis_tvalid = 1'b0;
    chk("f4_taken_tready", s_axis_tready, 0);
    step();
    chk("f4_tvalid", m_axis_tvalid, 1);
    chk("f4_word", m_axis_tdata, ew(40'h0000000007, 8'd0, 8'h07, 16'd3, 8'd6, 7'd7, 1'b0, 8'd0));
    accept();

    // Timeout after exactly 16 WAIT_RES cycles
    start(8'd200, 7'd100);
    for (int i = 0; i < 15; i++) step();
    chk("f5_early_tvalid", m_axis_tvalid, 0);
    step();
    chk("f5_tvalid", m_axis_tvalid, 1);
    chk("f5_word", m_axis_tdata, ew(40'h0, 8'd0, 8'd0, 16'd4, 8'd200, 7'd100, 1'b1, 8'd0));
    // Start coinciding with the output handshake is an overrun
    ap_start = 1'b1;
    accept();
    ap_start = 1'b0;
    chk("f5_busy", busy, 0);

    // Handshake on the 16th cycle beats the timeout
    start(8'd255, 7'd127);
    for (int i = 0; i < 15; i++) step();
    offer(40'h007F7F2010);
    chk("f6_race_tvalid", m_axis_tvalid, 0);
    step();
    chk("f6_word", m_axis_tdata, ew(40'h007F7F2010, 8'd2, 8'h7F, 16'd5, 8'd255, 7'd127, 1'b0, 8'd1));
    accept();

    // Reset while SEND is pending
    start(8'd5, 7'd5);
    offer(40'h0102030405);
    step();
    chk("f7_tvalid", m_axis_tvalid, 1);
    reset = 1'b1;
    #1;
    chk("f7_rst_tvalid", m_axis_tvalid, 0);
    chk("f7_rst_tdata", m_axis_tdata, 0);
    chk("f7_rst_busy", busy, 0);
    step();
    reset = 1'b0;
    step(); step(); step();
    chk("f7_post_tvalid", m_axis_tvalid, 0);
    chk("f7_post_busy", busy, 0);

    start(8'd9, 7'd8);
    offer(40'h8080808180);
    step();
    chk("f8_word", m_axis_tdata, ew(40'h8080808180, 8'd1, 8'h81, 16'd0, 8'd9, 7'd8, 1'b0, 8'd0));
    accept();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
